// File: rtl/weighted_rr_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arb_pkg : shared arbiter helpers (clog2, reset pointer, weight slicing)  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`ifndef ARB_WGT_SLICE
`define ARB_WGT_SLICE(vec, k, w) vec[(k)*(w) +: (w)]
`endif

package arb_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Pointer reset value that makes channel 0 win the first arbitration.
  function automatic int rst_ptr(input int n_ch);
    return n_ch - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/weighted_rr_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_pick : combinational rotating-priority encoder, search from ptr+1     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rr_pick
  import arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   onehot_o,
  output logic [IDW-1:0] id_o,
  output logic           any_o
);

  int c;

  // Scan farthest-first so the nearest requester after ptr overwrites the rest.
  always_comb begin
    onehot_o = '0;
    id_o     = '0;
    any_o    = 1'b0;
    c        = 0;
    for (int s = N; s >= 1; s--) begin
      c = (int'(ptr_i) + s) % N;
      if (req_i[c]) begin
        onehot_o    = '0;
        onehot_o[c] = 1'b1;
        id_o        = IDW'(c);
        any_o       = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/weighted_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | weighted_rr_arbiter : N-channel weighted round-robin, registered grant   |
// | Optional grant lock input enabled by defining WRR_LOCK_EN.   Rev 1.0     |
// +--------------------------------------------------------------------------+
module weighted_rr_arbiter
  import arb_pkg::*;
#(
  parameter int  N_CH  = 4,
  parameter int  WGT_W = 4,
  localparam int IDW   = clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  asrst,
  input  logic                  en,
  input  logic [N_CH-1:0]       req_vld,
  input  logic [N_CH*WGT_W-1:0] i_weight,
`ifdef WRR_LOCK_EN
  input  logic                  i_lock,
`endif
  output logic [N_CH-1:0]       o_grant,
  output logic [IDW-1:0]        o_grant_id,
  output logic                  o_grant_vld
);

  logic [WGT_W-1:0] wgt [N_CH];

  genvar k;
  generate
    for (k = 0; k < N_CH; k++) begin : g_wgt
      assign wgt[k] = `ARB_WGT_SLICE(i_weight, k, WGT_W);
    end
  endgenerate

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WGT_W-1:0] credit_q, credit_d;
  logic [N_CH-1:0]  grant_q, grant_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             vld_q, vld_d;

  logic [N_CH-1:0]  pick_oh;
  logic [IDW-1:0]   pick_id;
  logic             pick_any;
  logic [WGT_W-1:0] pick_wgt;
  logic             cur_req;
  logic             lock_hold;

  rr_pick #(
    .N   (N_CH),
    .IDW (IDW)
  ) u_pick (
    .req_i    (req_vld),
    .ptr_i    (ptr_q),
    .onehot_o (pick_oh),
    .id_o     (pick_id),
    .any_o    (pick_any)
  );

  assign pick_wgt = wgt[pick_id];
  assign cur_req  = vld_q & req_vld[id_q];

`ifdef WRR_LOCK_EN
  assign lock_hold = i_lock;
`else
  assign lock_hold = 1'b0;
`endif

  // The owner is always ptr, so on expiry the pick scans it last: a lone
  // requester is re-picked and its credit reloaded, with no special case.
  always_comb begin
    ptr_d    = ptr_q;
    credit_d = credit_q;
    grant_d  = grant_q;
    id_d     = id_q;
    vld_d    = vld_q;
    if (!en) begin
      credit_d = '0;
      grant_d  = '0;
      id_d     = '0;
      vld_d    = 1'b0;
    end else if (cur_req && lock_hold) begin
      credit_d = credit_q;
    end else if (cur_req && (credit_q != '0)) begin
      credit_d = credit_q - WGT_W'(1);
    end else if (pick_any) begin
      grant_d  = pick_oh;
      id_d     = pick_id;
      vld_d    = 1'b1;
      ptr_d    = pick_id;
      credit_d = (pick_wgt == '0) ? '0 : pick_wgt - WGT_W'(1);
    end else begin
      credit_d = '0;
      grant_d  = '0;
      id_d     = '0;
      vld_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge asrst) begin
    if (asrst) begin
      ptr_q    <= IDW'(rst_ptr(N_CH));
      credit_q <= '0;
      grant_q  <= '0;
      id_q     <= '0;
      vld_q    <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      grant_q  <= grant_d;
      id_q     <= id_d;
      vld_q    <= vld_d;
    end
  end

  assign o_grant     = grant_q;
  assign o_grant_id  = id_q;
  assign o_grant_vld = vld_q;

endmodule
`default_nettype wire
